// File: rtl/mips_pkg.sv
// Shared encodings for the MEM stage: op codes, access FSM states and the timeout default.
// The MEM_SUBWORD_EN build of mem_stage_access passes subword_en = 1 to decode_op.
package mips_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ALU = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_SW  = 4'd3;
  localparam logic [3:0] OP_BR  = 4'd4;
  localparam logic [3:0] OP_J   = 4'd5;
  localparam logic [3:0] OP_LB  = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd7;

  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_ALU   = 2'd1,
    K_LOAD  = 2'd2,
    K_STORE = 2'd3
  } op_kind_e;

  typedef struct packed {
    op_kind_e kind;
    logic     is_byte;
  } op_dec_t;

  // Branches, jumps, undefined codes and (without sub-word support) LB/SB all retire as NOP.
  function automatic op_dec_t decode_op(input logic [3:0] op, input logic subword_en);
    op_dec_t d;
    d.kind    = K_NONE;
    d.is_byte = 1'b0;
    case (op)
      OP_ALU: d.kind = K_ALU;
      OP_LW:  d.kind = K_LOAD;
      OP_SW:  d.kind = K_STORE;
      OP_LB: begin
        if (subword_en) begin
          d.kind    = K_LOAD;
          d.is_byte = 1'b1;
        end
      end
      OP_SB: begin
        if (subword_en) begin
          d.kind    = K_STORE;
          d.is_byte = 1'b1;
        end
      end
      default: d.kind = K_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating access-cycle counter; expired_o flags the LIMIT-th enabled cycle since the last clear.
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturation keeps expiry asserted if a load is granted on its last allowed cycle.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage load/store unit: drives the req/gnt/rvalid data bus, stalls the front end, registers WB fields.
// Define MEM_SUBWORD_EN to enable OP_LB/OP_SB with byte enables and LB sign extension.
module mem_stage_access
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        op_type,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       write_mem_data,
  input  logic [4:0]        write_reg_address,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_en,
  output logic [4:0]        wb_reg_address,
  output logic [31:0]       wb_data,
  output logic              align_err,
  output logic              bus_err
);

`ifdef MEM_SUBWORD_EN
  localparam logic SubwordEn = 1'b1;
`else
  localparam logic SubwordEn = 1'b0;
`endif

  state_e state_q, state_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              mem_we_q, mem_we_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;

  op_dec_t     dec;
  logic        acc_op;
  logic        misalign;
  logic        accept;
  logic        load_done;
  logic        abort;
  logic        expired;
  logic [31:0] load_val;

  assign dec      = decode_op(op_type, SubwordEn);
  assign acc_op   = (dec.kind == K_LOAD) || (dec.kind == K_STORE);
  assign misalign = acc_op && !dec.is_byte && (alu_result[1:0] != 2'b00);
  assign accept   = (state_q == IDLE) && acc_op && !misalign;
  assign load_done = (state_q == WAIT) && mem_rvalid;
  // A grant or read data in the expiry cycle counts as progress, so no abort then.
  assign abort    = expired && (((state_q == REQ) && !mem_gnt) ||
                                ((state_q == WAIT) && !mem_rvalid));

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (accept),
    .en_i      (state_q != IDLE),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = mem_we_q ? IDLE : WAIT;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_rvalid || expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // stall falls in the completion/abort cycle so EX/MEM advances on the retiring edge.
  always_comb begin
    mem_req = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: stall = accept;
      REQ: begin
        mem_req = 1'b1;
        stall   = mem_gnt ? !mem_we_q : !expired;
      end
      WAIT:    stall = !(mem_rvalid || expired);
      default: stall = 1'b0;
    endcase
  end

`ifdef MEM_SUBWORD_EN
  logic [7:0] rd_lane [4];
  logic [1:0] off_q, off_d;
  logic       byte_q, byte_d;
  logic [7:0] sel_byte;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = mem_rdata[8*gi +: 8];
  end

  assign sel_byte = rd_lane[off_q];
  assign load_val = byte_q ? {{24{sel_byte[7]}}, sel_byte} : 32'(mem_rdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_q  <= 2'b00;
      byte_q <= 1'b0;
    end else begin
      off_q  <= off_d;
      byte_q <= byte_d;
    end
  end
`else
  assign load_val = 32'(mem_rdata);
`endif

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    rd_d        = rd_q;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    wb_en_d     = 1'b0;
    align_err_d = 1'b0;
    bus_err_d   = abort;
`ifdef MEM_SUBWORD_EN
    off_d       = off_q;
    byte_d      = byte_q;
`endif
    if (state_q == IDLE) begin
      if (dec.kind == K_ALU) begin
        wb_data_d = alu_result;
        wb_reg_d  = write_reg_address;
        wb_en_d   = (write_reg_address != 5'd0);
      end
      align_err_d = acc_op && misalign;
      if (accept) begin
        mem_addr_d  = ADDR_W'({alu_result[31:2], 2'b00});
        mem_wdata_d = DATA_W'(write_mem_data);
        mem_we_d    = (dec.kind == K_STORE);
        rd_d        = write_reg_address;
`ifdef MEM_SUBWORD_EN
        off_d  = alu_result[1:0];
        byte_d = dec.is_byte;
        if (dec.is_byte) begin
          mem_be_d    = 4'b0001 << alu_result[1:0];
          mem_wdata_d = DATA_W'({4{write_mem_data[7:0]}});
        end else begin
          mem_be_d = 4'b1111;
        end
`else
        mem_be_d = 4'b1111;
`endif
      end
    end
    if (load_done) begin
      wb_data_d = load_val;
      wb_reg_d  = rd_q;
      wb_en_d   = (rd_q != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b1111;
      rd_q        <= 5'd0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= 5'd0;
      wb_data_q   <= 32'd0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      rd_q        <= rd_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_we         = mem_we_q;
  assign mem_be         = mem_be_q;
  assign wb_en          = wb_en_q;
  assign wb_reg_address = wb_reg_q;
  assign wb_data        = wb_data_q;
  assign align_err      = align_err_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: transaction-level model of the MEM stage, directed cases plus random ops.
module tb_mem_stage_access;
  import mips_pkg::*;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op_type;
  logic [31:0] alu_result, write_mem_data;
  logic [4:0]  write_reg_address;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall, wb_en;
  logic [4:0]  wb_reg_address;
  logic [31:0] wb_data;
  logic        align_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_access #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .op_type           (op_type),
    .alu_result        (alu_result),
    .write_mem_data    (write_mem_data),
    .write_reg_address (write_reg_address),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_be            (mem_be),
    .mem_gnt           (mem_gnt),
    .mem_rvalid        (mem_rvalid),
    .mem_rdata         (mem_rdata),
    .stall             (stall),
    .wb_en             (wb_en),
    .wb_reg_address    (wb_reg_address),
    .wb_data           (wb_data),
    .align_err         (align_err),
    .bus_err           (bus_err)
  );

  // Model: outstanding access (0 none, 1 awaiting grant, 2 awaiting data) and expected WB outputs.
  int          m_acc = 0;
  int          m_n = 0;
  int          m_off = 0;
  bit          m_store, m_byte;
  logic [4:0]  m_rd;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          e_wb_en, e_align, e_bus;
  logic [31:0] e_wb_data;
  logic [4:0]  e_wb_reg;

  // 0 nop, 1 alu, 2 word load, 3 word store, 4 byte load, 5 byte store
  function automatic int kind(input logic [3:0] op);
    case (op)
      4'd1: return 1;
      4'd2: return 2;
      4'd3: return 3;
`ifdef MEM_SUBWORD_EN
      4'd6: return 4;
      4'd7: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [4:0] rg, input logic g, input logic rv,
                      input logic [31:0] rd, output bit st);
    bit es, er;
    int k;
    logic [7:0] b;
    op_type = op; alu_result = alu; write_mem_data = wd; write_reg_address = rg;
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    #1;
    es = 0; er = 0; e_wb_en = 0; e_align = 0; e_bus = 0;
    if (m_acc == 0) begin
      k = kind(op);
      if (k == 1) begin
        e_wb_en = (rg != 0); e_wb_data = alu; e_wb_reg = rg;
      end else if ((k == 2 || k == 3) && alu[1:0] != 2'b00) begin
        e_align = 1;
      end else if (k >= 2) begin
        es = 1; m_acc = 1; m_n = 0; m_rd = rg;
        m_store = (k == 3 || k == 5);
        m_byte  = (k >= 4);
        m_addr  = {alu[31:2], 2'b00};
        m_off   = int'(alu[1:0]);
        m_be    = m_byte ? (4'b0001 << alu[1:0]) : 4'b1111;
        m_wdata = m_byte ? {4{wd[7:0]}} : wd;
      end
    end else if (m_acc == 1) begin
      m_n++; er = 1;
      if (g) begin
        if (m_store) m_acc = 0;
        else begin m_acc = 2; es = 1; end
      end else if (m_n >= T) begin
        m_acc = 0; e_bus = 1;
      end else es = 1;
    end else begin
      m_n++;
      if (rv) begin
        m_acc = 0; e_wb_en = (m_rd != 0); e_wb_reg = m_rd;
        b = rd[8*m_off +: 8];
        e_wb_data = m_byte ? {{24{b[7]}}, b} : rd;
      end else if (m_n >= T) begin
        m_acc = 0; e_bus = 1;
      end else es = 1;
    end
    chk("stall", stall, es);
    chk("mem_req", mem_req, er);
    if (er) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_store);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_be", mem_be, m_be);
    end
    @(posedge clk);
    #1;
    chk("wb_en", wb_en, e_wb_en);
    chk("align_err", align_err, e_align);
    chk("bus_err", bus_err, e_bus);
    if (e_wb_en) begin
      chk("wb_data", wb_data, e_wb_data);
      chk("wb_reg", wb_reg_address, e_wb_reg);
    end
    st = es;
  endtask

  // Present one op until it retires; partial > 0 stops after that many cycles instead.
  task automatic do_op(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rg, input int gdly, input int rdly,
                       input logic [31:0] rd, input int partial, output int ncyc);
    int req_n, wait_n, limit;
    bit st, done;
    logic g, rv;
    req_n = 0; wait_n = 0; done = 0; ncyc = 0;
    limit = (partial > 0) ? partial : 600;
    while (!done && ncyc < limit) begin
      g  = (m_acc == 1) ? (req_n == gdly) : ((m_acc == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      rv = (m_acc == 2) && (wait_n == rdly);
      if (m_acc == 1) req_n++;
      if (m_acc == 2) wait_n++;
      step(op, alu, wd, rg, g, rv, rd, st);
      done = !st;
      ncyc++;
    end
    if (!done && partial == 0) begin
      checks++; errors++;
      $display("FAIL op_bound actual=%0d cycles required=retire op=%0d", ncyc, op);
    end
  endtask

  task automatic mid_reset(input logic [31:0] late_data);
    bit st;
    #2;
    reset = 1'b0;
    #1;
    chk("req_drop_on_reset", mem_req, 1'b0);
    m_acc = 0;
    op_type = OP_NOP; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_be", mem_be, 4'b1111);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_en", wb_en, 1'b0);
    reset = 1'b1;
    repeat (2) step(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, late_data, st);
    chk("late_rvalid_wb_en", wb_en, 1'b0);
  endtask

  initial begin
    int n;
    bit st;
    logic [3:0]  rop;
    logic [31:0] ralu;
    reset = 1'b0;
    op_type = OP_NOP; alu_result = '0; write_mem_data = '0; write_reg_address = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_be", mem_be, 4'b1111);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wb", {wb_en, align_err, bus_err}, 3'b000);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_reg", wb_reg_address, 5'd0);
    reset = 1'b1;

    do_op(OP_ALU, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0, 0, n);
    chk("alu_cycles", n, 1);
    chk("alu_wb_en", wb_en, 1'b1);
    chk("alu_wb_reg", wb_reg_address, 5'd5);
    chk("alu_wb_data", wb_data, 32'h1234);

    do_op(OP_LW, 32'h100, 32'h0, 5'd7, 2, 3, 32'hDEADBEEF, 0, n);
    chk("lw_cycles", n, 8);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wb_reg", wb_reg_address, 5'd7);

    do_op(OP_LW, 32'h44, 32'h0, 5'd9, 0, 0, 32'h12345678, 0, n);
    chk("lw_zero_wait_cycles", n, 3);
    chk("lw_zero_wait_data", wb_data, 32'h12345678);

    do_op(OP_SW, 32'h40, 32'hA5A5_0F0F, 5'd3, 0, 0, 32'h0, 0, n);
    chk("sw_cycles", n, 2);
    chk("sw_wb_en", wb_en, 1'b0);
    chk("sw_wdata", mem_wdata, 32'hA5A5_0F0F);

    do_op(OP_SW, 32'h203, 32'h1, 5'd3, 0, 0, 32'h0, 0, n);
    chk("misalign_cycles", n, 1);
    chk("misalign_err", align_err, 1'b1);
    chk("misalign_wb_en", wb_en, 1'b0);

    do_op(OP_LW, 32'h80, 32'h0, 5'd0, 0, 0, 32'hFFFF_0000, 0, n);
    chk("lw_r0_wb_en", wb_en, 1'b0);

    do_op(OP_SW, 32'h300, 32'h5, 5'd1, 100000, 0, 32'h0, 0, n);
    chk("timeout_cycles", n, 256);
    chk("timeout_bus_err", bus_err, 1'b1);
    step(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, st);
    chk("timeout_pulse_end", bus_err, 1'b0);

    do_op(OP_SW, 32'h304, 32'h6, 5'd1, 254, 0, 32'h0, 0, n);
    chk("coincide_cycles", n, 256);
    chk("coincide_no_bus_err", bus_err, 1'b0);

    do_op(OP_LW, 32'h10, 32'h0, 5'd4, 100000, 0, 32'h0, 3, n);
    mid_reset(32'hCAFE_F00D);
    do_op(OP_LW, 32'h14, 32'h0, 5'd4, 0, 100000, 32'h0, 3, n);
    mid_reset(32'hBEEF_0001);

`ifdef MEM_SUBWORD_EN
    do_op(OP_LB, 32'h2, 32'h0, 5'd6, 0, 1, 32'h0080_0000, 0, n);
    chk("lb_be", mem_be, 4'b0100);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    do_op(OP_SB, 32'h7, 32'h0000_00C3, 5'd0, 1, 0, 32'h0, 0, n);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hC3C3_C3C3);
`endif

    for (int i = 0; i < 400; i++) begin
      rop  = 4'($urandom_range(0, 9));
      ralu = $urandom;
      if ($urandom_range(0, 3) != 0) ralu[1:0] = 2'b00;
      do_op(rop, ralu, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Decodes op_type and performs loads and stores on the data-memory bus using a req/gnt/rvalid handshake.
- Stalls the front of the pipeline (IF/ID/EX and the EX/MEM register) until each access completes.
- Produces registered write-back fields for the MEM/WB register.

Parameters:
- ADDR_W, 32, data-memory byte address width.
- DATA_W, 32, data word width (fixed at 32 for sub-word logic).
- TIMEOUT_CYC, 255, maximum cycles spent in REQ plus WAIT before an access is aborted.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_type  in  4  from EX/MEM; encodings are defined in mips_pkg.
- alu_result  in  32  ALU result; for loads and stores, the byte address.
- write_mem_data  in  32  store data.
- write_reg_address  in  5  destination register.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  word-aligned bus address.
- mem_wdata  out  DATA_W  store data on the bus.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- stall  out  1  hold the EX/MEM register and all earlier stages.
- wb_en  out  1  registered register-file write enable.
- wb_reg_address  out  5  registered destination register.
- wb_data  out  32  registered write-back data.
- align_err  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on an access timeout.

Behaviour:
- Op encodings (mips_pkg):
  - OP_NOP = 0, OP_ALU = 1, OP_LW = 2, OP_SW = 3, OP_BR = 4, OP_J = 5, OP_LB = 6, OP_SB = 7.
  - Undefined codes are treated as OP_NOP.
- Reset (reset = 0, asynchronous):
  - state = IDLE, timeout counter = 0.
  - mem_req, mem_we, wb_en, align_err, bus_err = 0.
  - mem_addr, mem_wdata, wb_data, wb_reg_address = 0; mem_be = 4'b1111.
  - A reset mid-access drops mem_req immediately. An mem_rvalid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE with OP_ALU:
  - stall = 0.
  - Next edge: wb_data = alu_result, wb_reg_address = write_reg_address, wb_en = (write_reg_address != 0).
- IDLE with OP_NOP, OP_BR or OP_J:
  - stall = 0; next edge wb_en = 0.
- IDLE with a load or store:
  - If misaligned (LW/SW and alu_result[1:0] != 0): no bus request; stall = 0; next edge align_err = 1 and wb_en = 0.
  - Otherwise: stall = 1. Next edge:
    - go to REQ;
    - register mem_addr = {alu_result[31:2], 2'b00} and mem_wdata;
    - register mem_we = (op is a store);
    - capture write_reg_address internally;
    - clear the counter.
- REQ:
  - mem_req = 1; addr, data and be are held stable until mem_gnt.
  - On mem_gnt:
    - store: access completes; stall = 0 in this cycle; next edge go to IDLE with wb_en = 0.
    - load: next edge go to WAIT, with mem_req = 0.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid: stall = 0 in this cycle. Next edge:
    - wb_data = mem_rdata (or the extracted sub-word);
    - wb_en = (captured reg != 0);
    - go to IDLE.
  - mem_gnt is ignored in WAIT.
- Stall (combinational):
  - stall = 1 while a valid load/store is in progress.
  - stall = 0 in the completion cycle, so EX/MEM advances on the same edge the result is registered.
- Load latency with zero-wait memory:
  - Op accepted in cycle 0; gnt in cycle 1; rvalid in cycle 2.
  - wb fields valid after the edge ending cycle 2; stall is high in cycles 0 and 1.
- Store latency with immediate gnt: 2 cycles of occupancy.
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - If it reaches TIMEOUT_CYC without completion: abort; next edge bus_err = 1, wb_en = 0, state = IDLE; stall = 0 in the abort cycle.
- Simultaneous gnt and counter expiry in the same cycle: completion wins, no bus_err.
- align_err and bus_err are single-cycle pulses; wb_en is a single-cycle pulse per retired op.

Optional Feature:
- Macro: MEM_SUBWORD_EN.
- Defined:
  - OP_LB and OP_SB are supported.
  - mem_be = 4'b0001 << alu_result[1:0] for byte ops; byte ops are never misaligned.
  - SB replicates write_mem_data[7:0] to all four lanes.
  - LB sign-extends the selected byte of mem_rdata; the byte offset is captured at accept.
- Undefined:
  - OP_LB and OP_SB are treated as OP_NOP.
  - mem_be is always 4'b1111.

Decomposition:
- mips_pkg: OP_* localparams, the state encoding (IDLE/REQ/WAIT) and the TIMEOUT_CYC default.
- One natural sub-module: mem_timeout_ctr, a counter with clear, enable and expired output.

Test Plan:
- OP_ALU, alu_result = 32'h1234, write_reg_address = 5 → stall = 0; next cycle wb_en = 1, wb_reg_address = 5, wb_data = 32'h1234.
- OP_LW at 32'h100, gnt after 2 cycles, rvalid with 32'hDEADBEEF 3 cycles later → mem_addr = 32'h100, stall high until the rvalid cycle, then wb_data = 32'hDEADBEEF.
- OP_SW at 32'h203 → no mem_req, align_err pulse, wb_en = 0, stall = 0.
- OP_LW with write_reg_address = 0 and rvalid = 1 → load completes, wb_en = 0.
- OP_SW with mem_gnt held low for 255 cycles → bus_err pulse, stall drops, state IDLE; with gnt and expiry coinciding → no bus_err.
- reset pulled low in WAIT, then a late mem_rvalid → mem_req = 0 immediately, wb_en stays 0; with MEM_SUBWORD_EN: OP_LB at addr 2 with rdata 32'h00800000 → mem_be = 4'b0100, wb_data = 32'hFFFFFF80.
